audio_gain_stage: RTL and testbench

//  Sample-processing stage between the I2S RX ADC FIFO (read side) and the I2S TX DAC FIFO (write side).
//  - Pops packed stereo words and applies a per-channel Q4.12 gain.
//  - Rounds and saturates each result, then pushes it to the DAC FIFO.
//  - Pipelined with credit-based flow control: no sample is dropped or duplicated under DAC back-pressure.

---
 rtl/audio_gain_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_audio_gain_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_gain_stage.sv
// Audio gain stage: pops packed stereo samples from the ADC FIFO, applies a
// per-channel Q4.12 gain with round-half-up and saturation, and pushes the
// results into the DAC FIFO. A small output buffer absorbs DAC back-pressure;
// reads are only issued when the buffer is guaranteed to have room for every
// sample already in the pipeline, so nothing is ever dropped or duplicated.
module audio_gain_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN_W     = 16,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  bypass,
  input  logic [GAIN_W-1:0]     gain_l,
  input  logic [GAIN_W-1:0]     gain_r,
  input  logic                  clip_clr,
  input  logic                  adcfifo_empty,
  output logic                  adcfifo_read,
  input  logic [DATA_WIDTH-1:0] adcfifo_readdata,
  input  logic                  dacfifo_full,
  output logic                  dacfifo_write,
  output logic [DATA_WIDTH-1:0] dacfifo_writedata,
  output logic                  clip_l,
  output logic                  clip_r,
  output logic                  busy
);

  localparam int HALF_W = DATA_WIDTH / 2;
  localparam int FRAC_W = 12;
  localparam int PROD_W = HALF_W + GAIN_W + 1;
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Rounding constant and saturation limits, expressed at the width of the
  // rounded product so the comparisons stay signed and overflow-free.
  localparam logic signed [PROD_W:0] ROUND_K =
    $signed({{(PROD_W - FRAC_W + 1){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}});
  localparam logic signed [PROD_W:0] SAT_MAX =
    $signed({{(PROD_W - HALF_W + 2){1'b0}}, {(HALF_W - 1){1'b1}}});
  localparam logic signed [PROD_W:0] SAT_MIN =
    $signed({{(PROD_W - HALF_W + 2){1'b1}}, {(HALF_W - 1){1'b0}}});

  // Signed sample times unsigned gain; both operands are widened to the full
  // product width first so the multiply is a plain signed one.
  function automatic logic signed [PROD_W-1:0] mul_sg(
    input logic [HALF_W-1:0] x,
    input logic [GAIN_W-1:0] g
  );
    logic signed [PROD_W-1:0] xe;
    logic signed [PROD_W-1:0] ge;
    xe = $signed({{(PROD_W - HALF_W){x[HALF_W-1]}}, x});
    ge = $signed({{(PROD_W - GAIN_W){1'b0}}, g});
    mul_sg = xe * ge;
  endfunction

  // Round half up, drop the fraction bits, then clamp to the sample range.
  // The MSB of the result flags that clamping happened.
  function automatic logic [HALF_W:0] scale_sat(
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [PROD_W:0] sum;
    logic signed [PROD_W:0] r;
    sum = $signed({prod[PROD_W-1], prod}) + ROUND_K;
    r   = sum >>> FRAC_W;
    if (r > SAT_MAX) begin
      scale_sat = {1'b1, SAT_MAX[HALF_W-1:0]};
    end else if (r < SAT_MIN) begin
      scale_sat = {1'b1, SAT_MIN[HALF_W-1:0]};
    end else begin
      scale_sat = {1'b0, r[HALF_W-1:0]};
    end
  endfunction

  logic                     run_q, run_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]    s2_data_q, s2_data_d;
  logic [GAIN_W-1:0]        s2_gain_l_q, s2_gain_l_d;
  logic [GAIN_W-1:0]        s2_gain_r_q, s2_gain_r_d;
  logic                     s2_bypass_q, s2_bypass_d;
  logic                     s3_valid_q, s3_valid_d;
  logic [DATA_WIDTH-1:0]    s3_data_q, s3_data_d;
  logic signed [PROD_W-1:0] s3_prod_l_q, s3_prod_l_d;
  logic signed [PROD_W-1:0] s3_prod_r_q, s3_prod_r_d;
  logic                     s3_bypass_q, s3_bypass_d;
  logic [DATA_WIDTH-1:0]    buf_mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         buf_count_q, buf_count_d;
  logic                     clip_l_q, clip_l_d;
  logic                     clip_r_q, clip_r_d;

  logic [CNT_W-1:0]         inflight;
  logic [CNT_W:0]           occupancy;
  logic                     rd_issue;
  logic                     push;
  logic                     pop;
  logic [HALF_W:0]          sat_l;
  logic [HALF_W:0]          sat_r;
  logic [DATA_WIDTH-1:0]    push_data;

  // Read issue: credit covers everything in the pipeline plus the buffer.
  // run_q keeps the read strobe low while reset is held.
  always_comb begin
    run_d     = 1'b1;
    inflight  = CNT_W'(s1_valid_q) + CNT_W'(s2_valid_q) + CNT_W'(s3_valid_q);
    occupancy = (CNT_W + 1)'(inflight) + (CNT_W + 1)'(buf_count_q);
    rd_issue  = run_q && enable && !adcfifo_empty &&
                (occupancy < (CNT_W + 1)'(BUF_DEPTH));
  end

  // Pipeline advance: S1 captures the word with the gains of that cycle,
  // S2 forms both products; payload registers hold when their stage is idle.
  always_comb begin
    s1_valid_d  = rd_issue;
    s2_valid_d  = s1_valid_q;
    s2_data_d   = s2_data_q;
    s2_gain_l_d = s2_gain_l_q;
    s2_gain_r_d = s2_gain_r_q;
    s2_bypass_d = s2_bypass_q;
    s3_valid_d  = s2_valid_q;
    s3_data_d   = s3_data_q;
    s3_prod_l_d = s3_prod_l_q;
    s3_prod_r_d = s3_prod_r_q;
    s3_bypass_d = s3_bypass_q;
    if (s1_valid_q) begin
      s2_data_d   = adcfifo_readdata;
      s2_gain_l_d = gain_l;
      s2_gain_r_d = gain_r;
      s2_bypass_d = bypass;
    end
    if (s2_valid_q) begin
      s3_data_d   = s2_data_q;
      s3_prod_l_d = mul_sg(s2_data_q[DATA_WIDTH-1:HALF_W], s2_gain_l_q);
      s3_prod_r_d = mul_sg(s2_data_q[HALF_W-1:0], s2_gain_r_q);
      s3_bypass_d = s2_bypass_q;
    end
  end

  // S3: round and saturate each channel, or pass the raw word in bypass.
  always_comb begin
    sat_l     = scale_sat(s3_prod_l_q);
    sat_r     = scale_sat(s3_prod_r_q);
    push_data = s3_bypass_q ? s3_data_q : {sat_l[HALF_W-1:0], sat_r[HALF_W-1:0]};
  end

  // Output buffer bookkeeping: push from S3, pop whenever the DAC has room.
  always_comb begin
    push        = s3_valid_q;
    pop         = (buf_count_q != '0) && !dacfifo_full;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    buf_count_d = buf_count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Sticky clip flags: a new clip in the same cycle as a clear wins.
  always_comb begin
    clip_l_d = clip_l_q;
    clip_r_d = clip_r_q;
    if (clip_clr) begin
      clip_l_d = 1'b0;
      clip_r_d = 1'b0;
    end
    if (push && !s3_bypass_q && sat_l[HALF_W]) begin
      clip_l_d = 1'b1;
    end
    if (push && !s3_bypass_q && sat_r[HALF_W]) begin
      clip_r_d = 1'b1;
    end
  end

  // Control and pipeline state; reset discards anything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_gain_l_q <= '0;
      s2_gain_r_q <= '0;
      s2_bypass_q <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_data_q   <= '0;
      s3_prod_l_q <= '0;
      s3_prod_r_q <= '0;
      s3_bypass_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      buf_count_q <= '0;
      clip_l_q    <= 1'b0;
      clip_r_q    <= 1'b0;
    end else begin
      run_q       <= run_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_gain_l_q <= s2_gain_l_d;
      s2_gain_r_q <= s2_gain_r_d;
      s2_bypass_q <= s2_bypass_d;
      s3_valid_q  <= s3_valid_d;
      s3_data_q   <= s3_data_d;
      s3_prod_l_q <= s3_prod_l_d;
      s3_prod_r_q <= s3_prod_r_d;
      s3_bypass_q <= s3_bypass_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      buf_count_q <= buf_count_d;
      clip_l_q    <= clip_l_d;
      clip_r_q    <= clip_r_d;
    end
  end

  // Buffer storage; cleared on reset so the write data bus idles at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem_q[i] <= '0;
      end
    end else if (push) begin
      buf_mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign adcfifo_read      = rd_issue;
  assign dacfifo_write     = pop;
  assign dacfifo_writedata = buf_mem_q[rd_ptr_q];
  assign clip_l            = clip_l_q;
  assign clip_r            = clip_r_q;
  assign busy              = s1_valid_q | s2_valid_q | s3_valid_q | (buf_count_q != '0);

endmodule

// File: tb/tb_audio_gain_stage.sv
// Testbench for audio_gain_stage: a non-FWFT ADC FIFO model feeds words,
// expected outputs are queued at load time and compared as the DAC side writes.
module tb_audio_gain_stage;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        bypass;
  logic [15:0] gain_l;
  logic [15:0] gain_r;
  logic        clip_clr;
  logic        adcfifo_empty;
  logic        adcfifo_read;
  logic [31:0] adcfifo_readdata;
  logic        dacfifo_full;
  logic        dacfifo_write;
  logic [31:0] dacfifo_writedata;
  logic        clip_l;
  logic        clip_r;
  logic        busy;

  logic [31:0] adc_q[$];
  logic [31:0] exp_q[$];
  int pass_cnt = 0;
  int check_cnt = 0;
  int cyc = 0;
  int rd_count = 0;
  int wr_count = 0;
  int first_rd = -1;
  int first_wr = -1;

  audio_gain_stage #(
    .DATA_WIDTH(32),
    .GAIN_W(16),
    .BUF_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .bypass(bypass),
    .gain_l(gain_l),
    .gain_r(gain_r),
    .clip_clr(clip_clr),
    .adcfifo_empty(adcfifo_empty),
    .adcfifo_read(adcfifo_read),
    .adcfifo_readdata(adcfifo_readdata),
    .dacfifo_full(dacfifo_full),
    .dacfifo_write(dacfifo_write),
    .dacfifo_writedata(dacfifo_writedata),
    .clip_l(clip_l),
    .clip_r(clip_r),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic for one channel: round half up, then clamp.
  function automatic logic [15:0] chan_model(input logic [15:0] x, input logic [15:0] g);
    longint p;
    longint r;
    p = longint'($signed(x)) * longint'(g);
    r = (p + 2048) >>> 12;
    if (r > 32767) return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return r[15:0];
  endfunction

  function automatic logic [31:0] word_model(input logic [31:0] w, input logic [15:0] gl,
                                             input logic [15:0] gr, input logic byp);
    if (byp) return w;
    return {chan_model(w[31:16], gl), chan_model(w[15:0], gr)};
  endfunction

  // Queue a word in the ADC FIFO and its expected output in the scoreboard.
  task automatic load_word(input logic [31:0] w);
    adc_q.push_back(w);
    exp_q.push_back(word_model(w, gain_l, gain_r, bypass));
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      next();
      if (exp_q.size() == 0 && !busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ADC FIFO model and DAC-side scoreboard: strobes are sampled on the
  // falling edge, read data appears just after the following rising edge.
  initial begin
    logic rd;
    logic [31:0] exp_w;
    adcfifo_empty = 1'b1;
    adcfifo_readdata = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      rd = adcfifo_read;
      if (rd) begin
        rd_count++;
        if (first_rd < 0) first_rd = cyc;
        check_cnt++;
        if (adcfifo_empty !== 1'b0)
          $display("[TB] FAIL read_when_empty: got read with empty=%b, required empty=0", adcfifo_empty);
        else pass_cnt++;
      end
      if (dacfifo_write) begin
        wr_count++;
        if (first_wr < 0) first_wr = cyc;
        check_cnt++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL dac_unexpected: got write %h, required no write", dacfifo_writedata);
        end else begin
          exp_w = exp_q.pop_front();
          if (dacfifo_writedata !== exp_w)
            $display("[TB] FAIL dac_data: got %h, required %h", dacfifo_writedata, exp_w);
          else pass_cnt++;
        end
      end
      @(posedge clk);
      #1;
      if (rd && adc_q.size() > 0) adcfifo_readdata = adc_q.pop_front();
      adcfifo_empty = (adc_q.size() == 0);
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_cnt++; if (adcfifo_read !== 1'b0) $display("[TB] FAIL reset_read: got %b, required 0", adcfifo_read); else pass_cnt++;
    check_cnt++; if (dacfifo_write !== 1'b0) $display("[TB] FAIL reset_write: got %b, required 0", dacfifo_write); else pass_cnt++;
    check_cnt++; if (dacfifo_writedata !== 32'h0) $display("[TB] FAIL reset_wdata: got %h, required 0", dacfifo_writedata); else pass_cnt++;
    check_cnt++; if (clip_l !== 1'b0) $display("[TB] FAIL reset_clip_l: got %b, required 0", clip_l); else pass_cnt++;
    check_cnt++; if (clip_r !== 1'b0) $display("[TB] FAIL reset_clip_r: got %b, required 0", clip_r); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, required 0", busy); else pass_cnt++;
    next();
    reset_n = 1'b1;
    repeat (2) next();
  endtask

  task automatic test_unity();
    bit to;
    int wr0;
    gain_l = 16'h1000;
    gain_r = 16'h1000;
    bypass = 1'b0;
    for (int i = 0; i < 8; i++) load_word(32'h1234EDCB + 32'(i) * 32'h01010101);
    wr0 = wr_count;
    first_rd = -1;
    first_wr = -1;
    enable = 1'b1;
    wait_drain(200, to);
    enable = 1'b0;
    check_cnt++; if (to) $display("[TB] FAIL unity_drain: got %0d words pending, required 0", exp_q.size()); else pass_cnt++;
    check_cnt++; if (wr_count - wr0 != 8) $display("[TB] FAIL unity_count: got %0d writes, required 8", wr_count - wr0); else pass_cnt++;
    check_cnt++;
    if (first_wr - first_rd != 4) $display("[TB] FAIL unity_latency: got %0d cycles, required 4", first_wr - first_rd);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    bit to;
    bit seen;
    gain_l = 16'h2000;
    gain_r = 16'h2000;
    load_word(32'h4000B1E0);
    enable = 1'b1;
    wait_drain(50, to);
    enable = 1'b0;
    check_cnt++; if (to) $display("[TB] FAIL sat_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
    check_cnt++; if (clip_l !== 1'b1) $display("[TB] FAIL sat_clip_l: got %b, required 1", clip_l); else pass_cnt++;
    check_cnt++; if (clip_r !== 1'b1) $display("[TB] FAIL sat_clip_r: got %b, required 1", clip_r); else pass_cnt++;
    clip_clr = 1'b1;
    next();
    clip_clr = 1'b0;
    check_cnt++; if (clip_l !== 1'b0) $display("[TB] FAIL clr_clip_l: got %b, required 0", clip_l); else pass_cnt++;
    check_cnt++; if (clip_r !== 1'b0) $display("[TB] FAIL clr_clip_r: got %b, required 0", clip_r); else pass_cnt++;
    // Clear held high while a left-only clip lands: the set must win.
    clip_clr = 1'b1;
    load_word(32'h7FFF0001);
    enable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dacfifo_write) begin
        seen = 1'b1;
        break;
      end
    end
    check_cnt++; if (!seen) $display("[TB] FAIL setwin_write: got no write, required write"); else pass_cnt++;
    check_cnt++; if (clip_l !== 1'b1) $display("[TB] FAIL setwin_clip_l: got %b, required 1", clip_l); else pass_cnt++;
    check_cnt++; if (clip_r !== 1'b0) $display("[TB] FAIL setwin_clip_r: got %b, required 0", clip_r); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (clip_l !== 1'b0) $display("[TB] FAIL setwin_cleared: got %b, required 0", clip_l); else pass_cnt++;
    next();
    clip_clr = 1'b0;
    enable = 1'b0;
    wait_drain(50, to);
  endtask

  task automatic test_rounding();
    bit to;
    gain_l = 16'h0800;
    gain_r = 16'h0800;
    load_word(32'h0003FFFD);
    load_word(32'h0001FFFF);
    enable = 1'b1;
    wait_drain(50, to);
    enable = 1'b0;
    check_cnt++; if (to) $display("[TB] FAIL round_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
    check_cnt++;
    if ({clip_l, clip_r} !== 2'b00) $display("[TB] FAIL round_clip: got %b, required 00", {clip_l, clip_r});
    else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    bit to;
    int rd0;
    int wr0;
    gain_l = 16'h1000;
    gain_r = 16'h1000;
    dacfifo_full = 1'b1;
    rd0 = rd_count;
    wr0 = wr_count;
    for (int i = 0; i < 10; i++) load_word(32'h00100020 * 32'(i + 1) + 32'h80008000);
    enable = 1'b1;
    repeat (20) next();
    check_cnt++; if (rd_count - rd0 != 4) $display("[TB] FAIL bp_reads: got %0d, required 4", rd_count - rd0); else pass_cnt++;
    check_cnt++; if (wr_count != wr0) $display("[TB] FAIL bp_writes: got %0d, required 0", wr_count - wr0); else pass_cnt++;
    check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL bp_busy: got %b, required 1", busy); else pass_cnt++;
    dacfifo_full = 1'b0;
    wait_drain(200, to);
    enable = 1'b0;
    check_cnt++; if (to) $display("[TB] FAIL bp_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
    check_cnt++; if (wr_count - wr0 != 10) $display("[TB] FAIL bp_total: got %0d writes, required 10", wr_count - wr0); else pass_cnt++;
    check_cnt++; if (rd_count - rd0 != 10) $display("[TB] FAIL bp_total_reads: got %0d, required 10", rd_count - rd0); else pass_cnt++;
  endtask

  task automatic test_bypass_enable();
    bit to;
    int rd0;
    int snap;
    int n;
    bypass = 1'b1;
    gain_l = 16'h0000;
    gain_r = 16'h0000;
    for (int i = 0; i < 6; i++) load_word($urandom);
    enable = 1'b1;
    wait_drain(100, to);
    enable = 1'b0;
    check_cnt++; if (to) $display("[TB] FAIL byp_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
    // Gains that would clip in the normal path must not touch the flags here.
    gain_l = 16'hFFFF;
    gain_r = 16'hFFFF;
    rd0 = rd_count;
    for (int i = 0; i < 12; i++) load_word(32'h7FFF8000 ^ 32'(i));
    enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      next();
      if (rd_count - rd0 >= 3) break;
    end
    enable = 1'b0;
    snap = rd_count;
    check_cnt++; if (snap - rd0 < 3) $display("[TB] FAIL en_start: got %0d reads, required >= 3", snap - rd0); else pass_cnt++;
    repeat (10) next();
    check_cnt++; if (rd_count != snap) $display("[TB] FAIL en_stop: got %0d extra reads, required 0", rd_count - snap); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL en_busy: got %b, required 0", busy); else pass_cnt++;
    n = adc_q.size();
    check_cnt++; if (exp_q.size() != n) $display("[TB] FAIL en_inflight: got %0d unwritten, required %0d", exp_q.size(), n); else pass_cnt++;
    check_cnt++;
    if ({clip_l, clip_r} !== 2'b00) $display("[TB] FAIL byp_clip: got %b, required 00", {clip_l, clip_r});
    else pass_cnt++;
    exp_q.delete();
    adc_q.delete();
    bypass = 1'b0;
    repeat (2) next();
  endtask

  task automatic test_reset_inflight();
    bit to;
    int rd0;
    int wr0;
    gain_l = 16'h1000;
    gain_r = 16'h1000;
    rd0 = rd_count;
    for (int i = 0; i < 8; i++) load_word(32'h0A0B0C0D + 32'(i));
    enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      next();
      if (rd_count - rd0 >= 3) break;
    end
    reset_n = 1'b0;
    @(negedge clk);
    check_cnt++; if (adcfifo_read !== 1'b0) $display("[TB] FAIL rst2_read: got %b, required 0", adcfifo_read); else pass_cnt++;
    check_cnt++; if (dacfifo_write !== 1'b0) $display("[TB] FAIL rst2_write: got %b, required 0", dacfifo_write); else pass_cnt++;
    check_cnt++; if (dacfifo_writedata !== 32'h0) $display("[TB] FAIL rst2_wdata: got %h, required 0", dacfifo_writedata); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rst2_busy: got %b, required 0", busy); else pass_cnt++;
    repeat (2) next();
    enable = 1'b0;
    adc_q.delete();
    exp_q.delete();
    reset_n = 1'b1;
    wr0 = wr_count;
    repeat (10) next();
    check_cnt++; if (wr_count != wr0) $display("[TB] FAIL rst2_nowrite: got %0d writes, required 0", wr_count - wr0); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rst2_idle: got %b, required 0", busy); else pass_cnt++;
    // The stage must recover and process new words normally.
    load_word(32'h11112222);
    enable = 1'b1;
    wait_drain(50, to);
    enable = 1'b0;
    check_cnt++; if (to) $display("[TB] FAIL rst2_recover: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    bypass = 1'b0;
    gain_l = 16'h0;
    gain_r = 16'h0;
    clip_clr = 1'b0;
    dacfifo_full = 1'b0;
    test_reset();
    test_unity();
    test_saturate();
    test_rounding();
    test_back_pressure();
    test_bypass_enable();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
